seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for an N-digit common-cathode 7-segment display.
- Holds N packed BCD digits in a double-buffered register and drives one shared BCD-to-ABCDEFG decode path.
- Walks digit enables one-hot, with a blanking gap between digits to prevent ghosting.
- Sits between the number-producing logic (counters, calculators) and the display pins.

---
 rtl/seg7_scan_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-cathode 7-segment display.
// Optional decimal-point support is enabled by defining SEG7_DECIMAL_POINT_EN.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 1000,
    parameter int GAP_CYCLES   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef SEG7_DECIMAL_POINT_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic                    load_ack,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              Segment
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [6:0]              segment_q, segment_d;
    logic                    start, wrap, commit;
    logic [3:0]              nib;
`ifdef SEG7_DECIMAL_POINT_EN
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    dp_q, dp_d;
`endif

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    // A digit is a leading zero when it and every more significant digit are 0.
    function automatic logic is_leading_zero(input logic [4*NUM_DIGITS-1:0] act,
                                             input logic [IDX_W-1:0]        idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && act[k*4 +: 4] != 4'd0) all_zero = 1'b0;
        end
        return (idx != '0) && all_zero;
    endfunction

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        wrap    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SCAN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            SCAN, GAP: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (state_q == SCAN && cnt_q != DIG_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (state_q == GAP && cnt_q != GAP_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (state_q == SCAN && GAP_CYCLES > 0) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // A load coinciding with a commit re-arms pending for the following wrap.
        commit    = pending_q && (start || wrap);
        active_d  = commit ? shadow_q : active_q;
        shadow_d  = load ? digits_in : shadow_q;
        pending_d = load || (pending_q && !commit);
`ifdef SEG7_DECIMAL_POINT_EN
        active_dp_d = commit ? shadow_dp_q : active_dp_q;
        shadow_dp_d = load ? dp_in : shadow_dp_q;
        dp_d        = (state_d == SCAN) ? active_dp_d[idx_d] : 1'b0;
`endif

        load_ack_d   = commit;
        frame_done_d = wrap;
        digit_en_d   = '0;
        segment_d    = '0;
        nib          = active_d[idx_d*4 +: 4];
        if (state_d == SCAN) begin
            digit_en_d[idx_d] = 1'b1;
            if (!(blank_lz && is_leading_zero(active_d, idx_d))) segment_d = decode(nib);
        end
    end

    // NOTE: the digit buffers are reset along with the control state so a
    // reset mid-scan leaves nothing stale to display or commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            digit_en_q   <= '0;
            segment_q    <= '0;
`ifdef SEG7_DECIMAL_POINT_EN
            active_dp_q  <= '0;
            shadow_dp_q  <= '0;
            dp_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
            digit_en_q   <= digit_en_d;
            segment_q    <= segment_d;
`ifdef SEG7_DECIMAL_POINT_EN
            active_dp_q  <= active_dp_d;
            shadow_dp_q  <= shadow_dp_d;
            dp_q         <= dp_d;
`endif
        end
    end

    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;
    assign digit_en   = digit_en_q;
    assign Segment    = segment_q;
`ifdef SEG7_DECIMAL_POINT_EN
    assign dp         = dp_q;
`endif

endmodule
